// File: rtl/nec_encoder.sv
// rtl/nec_encoder.sv - NEC IR transmitter (leader, 32 data bits LSB first, stop mark / repeat code) with AXI4-Lite registers
module nec_encoder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    output logic                            data_tx,
    output logic                            irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;

    state_t                  state, state_next;
    logic [31:0]             period_reg, data_reg, carr_reg, sh_period, sh_data;
    logic                    irq_en, done, repeat_mode, sh_rep;
    logic [CNT_WIDTH-1:0]    unit_cnt, carr_cnt, unit_reload;
    logic [4:0]              unit_left, load_units, bit_idx;
    logic                    carr_phase, load, seg_end, is_mark, done_set;
    logic                    wr_en, rd_en, csr_wr, start_go;
    logic                    unused_addr_bits;

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] period_m1(input logic [31:0] p);
        return (p == 32'd0) ? 32'd0 : p - 32'd1;
    endfunction

    assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_en    = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en    = S_AXI_ARREADY & S_AXI_ARVALID;
    assign csr_wr   = wr_en && (S_AXI_AWADDR[3:2] == 2'd0) && S_AXI_WSTRB[0];
    assign start_go = csr_wr && S_AXI_WDATA[0] && (state == IDLE);
    assign seg_end  = (unit_cnt == '0) && (unit_left == 5'd0);
    assign irq      = done & irq_en;
    assign S_AXI_WREADY = S_AXI_AWREADY;
    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RRESP  = 2'b00;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_AWREADY <= ~S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
            S_AXI_ARREADY <= ~S_AXI_ARREADY & S_AXI_ARVALID & ~S_AXI_RVALID;
            if (wr_en)             S_AXI_BVALID <= 1'b1;
            else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            if (rd_en) begin
                S_AXI_RVALID <= 1'b1;
                case (S_AXI_ARADDR[3:2])
                    2'd0:    S_AXI_RDATA <= {28'd0, repeat_mode, done, irq_en, state != IDLE};
                    2'd1:    S_AXI_RDATA <= period_reg;
                    2'd2:    S_AXI_RDATA <= data_reg;
                    default: S_AXI_RDATA <= carr_reg;
                endcase
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            period_reg  <= '0;
            data_reg    <= '0;
            carr_reg    <= '0;
            irq_en      <= 1'b0;
            repeat_mode <= 1'b0;
            done        <= 1'b0;
            sh_period   <= '0;
            sh_data     <= '0;
            sh_rep      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (S_AXI_AWADDR[3:2])
                    2'd0: if (S_AXI_WSTRB[0]) begin
                        irq_en      <= S_AXI_WDATA[1];
                        repeat_mode <= S_AXI_WDATA[3];
                    end
                    2'd1:    period_reg <= wmerge(period_reg, S_AXI_WDATA, S_AXI_WSTRB);
                    2'd2:    data_reg   <= wmerge(data_reg, S_AXI_WDATA, S_AXI_WSTRB);
                    default: carr_reg   <= wmerge(carr_reg, S_AXI_WDATA, S_AXI_WSTRB);
                endcase
            end
            // a finishing frame outranks a simultaneous W1C
            if (done_set)                       done <= 1'b1;
            else if (csr_wr && S_AXI_WDATA[2])  done <= 1'b0;
            if (start_go) begin
                sh_period <= period_reg;
                sh_data   <= data_reg;
                sh_rep    <= S_AXI_WDATA[3];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_units = 5'd0;
        case (state)
            IDLE:       if (start_go) state_next = LEAD_MARK;
            LEAD_MARK:  if (seg_end)  state_next = LEAD_SPACE;
            LEAD_SPACE: if (seg_end)  state_next = sh_rep ? STOP_MARK : BIT_MARK;
            BIT_MARK:   if (seg_end)  state_next = BIT_SPACE;
            BIT_SPACE:  if (seg_end)  state_next = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
            STOP_MARK:  if (seg_end)  state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
        load = (state_next != state) && (state_next != IDLE);
        case (state_next)
            LEAD_MARK:  load_units = 5'd15;
            LEAD_SPACE: load_units = sh_rep ? 5'd3 : 5'd7;
            BIT_SPACE:  load_units = sh_data[bit_idx] ? 5'd2 : 5'd0;
            default:    load_units = 5'd0;
        endcase
        unit_reload = CNT_WIDTH'(period_m1((state == IDLE) ? period_reg : sh_period));
    end

    always_comb begin
        is_mark  = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
        data_tx  = is_mark && ((carr_reg == 32'd0) || carr_phase);
        done_set = (state == STOP_MARK) && seg_end;
    end

    // unit_cnt counts cycles within a unit, unit_left counts remaining units in the segment
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            unit_cnt  <= '0;
            unit_left <= '0;
            bit_idx   <= '0;
        end else begin
            if (load) begin
                unit_cnt  <= unit_reload;
                unit_left <= load_units;
            end else if (state_next == IDLE) begin
                unit_cnt  <= '0;
                unit_left <= '0;
            end else if (unit_cnt == '0) begin
                unit_cnt  <= unit_reload;
                unit_left <= unit_left - 5'd1;
            end else begin
                unit_cnt  <= unit_cnt - 1'b1;
            end
            if (state == IDLE)                       bit_idx <= '0;
            else if (state == BIT_SPACE && seg_end)  bit_idx <= bit_idx + 5'd1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            carr_phase <= 1'b0;
            carr_cnt   <= '0;
        end else if (load && (state_next != LEAD_SPACE) && (state_next != BIT_SPACE)) begin
            carr_phase <= 1'b1;
            carr_cnt   <= CNT_WIDTH'(carr_reg - 32'd1);
        end else if (is_mark && carr_reg != 32'd0) begin
            if (carr_cnt == '0) begin
                carr_phase <= ~carr_phase;
                carr_cnt   <= CNT_WIDTH'(carr_reg - 32'd1);
            end else begin
                carr_cnt   <= carr_cnt - 1'b1;
            end
        end
    end
endmodule
